// File: rtl/ir_frame_ctrl.sv
// ir_frame_ctrl: validates decoded NEC frames, replays repeat codes inside a hold window, buffers key events in a FWFT FIFO.
// Latency: rx_complete rise to fifo_empty low in 3 cycles; repeat_in pulse to fifo_empty low in 2 cycles.
// Backpressure: none toward the receiver; an event arriving while the FIFO is full is dropped and latched in overflow.
//
// Build option: define IR_EXT_ADDR_EN for extended NEC (16-bit address). In that mode only the command complement
// is checked, and rd_data[23:16] carries the high address byte.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   rx_complete, rx_data   receiver frame-done level and decoded frame {cmd_inv, cmd, addr_inv, addr}
//   repeat_in              one-cycle NEC repeat pulse
//   rd_en                  pop request (ignored when empty)
//   clr                    one-cycle pulse clearing err_cnt and overflow
//   rd_data, rd_repeat     FIFO head {addr_hi, addr, cmd} and its repeat flag
//   fifo_empty, fifo_full  FIFO occupancy flags
//   overflow, err_cnt      sticky drop flag, saturating rejected-frame count
//   hold_active            repeat codes are currently accepted
module ir_frame_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 5500000,
  parameter int TMR_W       = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_complete,
  input  logic [31:0] rx_data,
  input  logic        repeat_in,
  input  logic        rd_en,
  input  logic        clr,
  output logic [23:0] rd_data,
  output logic        rd_repeat,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow,
  output logic [7:0]  err_cnt,
  output logic        hold_active
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PUSH  = 2'd2
  } state_t;

  state_t state, state_d;

  logic             rx_complete_q;
  logic             pend_frame, pend_rep;
  logic [31:0]      frame_q;
  logic [24:0]      push_q;        // {repeat flag, addr_hi, addr, cmd}
  logic [23:0]      last_event;
  logic [TMR_W-1:0] hold_tmr;

  logic [24:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic frame_evt;
  logic frame_ok;
  logic capture, rep_svc, load_rep, load_frame, frame_err, do_push;
  logic pop, push_ok;

  assign frame_evt   = rx_complete & ~rx_complete_q;
  assign hold_active = (hold_tmr != '0);

`ifdef IR_EXT_ADDR_EN
  assign frame_ok = (frame_q[31:24] == ~frame_q[23:16]);
`else
  assign frame_ok = (frame_q[31:24] == ~frame_q[23:16]) && (frame_q[15:8] == ~frame_q[7:0]);
`endif

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = rd_en & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok    = do_push & (~fifo_full | pop);

  assign rd_data    = mem[rd_ptr][23:0];
  assign rd_repeat  = mem[rd_ptr][24];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    capture    = 1'b0;
    rep_svc    = 1'b0;
    load_rep   = 1'b0;
    load_frame = 1'b0;
    frame_err  = 1'b0;
    do_push    = 1'b0;
    case (state)
      IDLE: begin
        // A frame always takes priority; a repeat seen in the same cycle is dropped.
        if (frame_evt || pend_frame) begin
          capture = 1'b1;
          state_d = CHECK;
        end else if (repeat_in || pend_rep) begin
          rep_svc = 1'b1;
          if (hold_active) begin
            load_rep = 1'b1;
            state_d  = PUSH;
          end
        end
      end
      CHECK: begin
        if (frame_ok) begin
          load_frame = 1'b1;
          state_d    = PUSH;
        end else begin
          frame_err = 1'b1;
          state_d   = IDLE;
        end
      end
      PUSH: begin
        do_push = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset high so a frame-done level already present at release is not seen as a new frame.
      rx_complete_q <= 1'b1;
      pend_frame    <= 1'b0;
      pend_rep      <= 1'b0;
      frame_q       <= '0;
      push_q        <= '0;
      last_event    <= '0;
      hold_tmr      <= '0;
      err_cnt       <= '0;
      overflow      <= 1'b0;
    end else begin
      rx_complete_q <= rx_complete;

      if (capture)                        pend_frame <= 1'b0;
      else if (frame_evt && state != IDLE) pend_frame <= 1'b1;

      if (rep_svc)                        pend_rep <= 1'b0;
      else if (repeat_in && state != IDLE) pend_rep <= 1'b1;

      if (capture) frame_q <= rx_data;

      if (load_rep) begin
        push_q <= {1'b1, last_event};
      end else if (load_frame) begin
        push_q     <= {1'b0, frame_q[15:8], frame_q[7:0], frame_q[23:16]};
        last_event <= {frame_q[15:8], frame_q[7:0], frame_q[23:16]};
      end

      // Reload even when the event is dropped for overflow: the key is still held.
      if (do_push)               hold_tmr <= TMR_W'(HOLD_CYCLES);
      else if (hold_tmr != '0)   hold_tmr <= hold_tmr - TMR_W'(1);

      if (clr)                              err_cnt <= '0;
      else if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (clr)                              overflow <= 1'b0;
      else if (do_push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_ctrl.sv
module tb_ir_frame_ctrl;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_complete;
  logic [31:0] rx_data;
  logic        repeat_in;
  logic        rd_en;
  logic        clr;
  logic [23:0] rd_data;
  logic        rd_repeat;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic [7:0]  err_cnt;
  logic        hold_active;

  int n_tests = 0;
  int n_fail  = 0;

  ir_frame_ctrl #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .TMR_W(23)) dut (
    .clk(clk), .reset(reset), .rx_complete(rx_complete), .rx_data(rx_data),
    .repeat_in(repeat_in), .rd_en(rd_en), .clr(clr), .rd_data(rd_data),
    .rd_repeat(rd_repeat), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow), .err_cnt(err_cnt), .hold_active(hold_active)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference rules: complement checks and the {addr_hi, addr, cmd} event layout.
  function automatic bit model_valid(input logic [31:0] f);
    logic [7:0] a, ai, c, ci;
    a = f[7:0]; ai = f[15:8]; c = f[23:16]; ci = f[31:24];
`ifdef IR_EXT_ADDR_EN
    return (c ^ ci) == 8'hFF;
`else
    return ((c ^ ci) == 8'hFF) && ((a ^ ai) == 8'hFF);
`endif
  endfunction

  function automatic logic [24:0] model_entry(input logic [31:0] f, input bit rep);
    return {rep, f[15:8], f[7:0], f[23:16]};
  endfunction

  function automatic logic [31:0] mk_valid(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  task automatic do_reset();
    reset = 1'b1; rx_complete = 1'b0; rx_data = '0; repeat_in = 1'b0; rd_en = 1'b0; clr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic send_frame(input logic [31:0] f);
    rx_data = f; rx_complete = 1'b1;
    tick(2);
    rx_complete = 1'b0;
    tick(3);
  endtask

  task automatic send_repeat();
    repeat_in = 1'b1;
    tick(1);
    repeat_in = 1'b0;
    tick(3);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] got;
    do_reset();
    got = {fifo_empty, fifo_full, overflow, hold_active, rd_repeat, rd_data, err_cnt};
    n_tests++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 8'h0}) begin
      n_fail++; $display("FAIL reset_state: got %h required %h", got, {5'b10000, 24'h0, 8'h0});
    end
  endtask

  task automatic test_valid_frame();
    do_reset();
    rx_data = 32'hF708FB04; rx_complete = 1'b1;
    tick(2);
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL frame_latency_early: empty=%b required 1", fifo_empty); end
    tick(1);
    n_tests++;
    if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL frame_latency: empty=%b required 0", fifo_empty); end
    n_tests++;
    if ({rd_repeat, rd_data} !== {1'b0, 24'hFB0408}) begin
      n_fail++; $display("FAIL frame_head: got %h required %h", {rd_repeat, rd_data}, {1'b0, 24'hFB0408});
    end
    n_tests++;
    if (hold_active !== 1'b1) begin n_fail++; $display("FAIL frame_hold: got %b required 1", hold_active); end
    rx_complete = 1'b0;
    pop_one();
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL frame_pop: empty=%b required 1", fifo_empty); end
  endtask

  task automatic test_bad_frame();
    do_reset();
    send_frame(32'hF608FB04);
    n_tests++;
    if ({fifo_empty, err_cnt} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL bad_cmd: empty=%b err=%0d required empty=1 err=1", fifo_empty, err_cnt);
    end
    send_frame(32'hF7081204);
`ifdef IR_EXT_ADDR_EN
    n_tests++;
    if ({fifo_empty, rd_data, err_cnt} !== {1'b0, 24'h120408, 8'd1}) begin
      n_fail++; $display("FAIL ext_addr: empty=%b data=%h err=%0d required 0/120408/1", fifo_empty, rd_data, err_cnt);
    end
    pop_one();
`else
    n_tests++;
    if ({fifo_empty, err_cnt} !== {1'b1, 8'd2}) begin
      n_fail++; $display("FAIL bad_addr: empty=%b err=%0d required empty=1 err=2", fifo_empty, err_cnt);
    end
`endif
  endtask

  task automatic test_repeat();
    do_reset();
    send_frame(32'hF708FB04);
    tick(995);
    repeat_in = 1'b1;
    tick(1);
    repeat_in = 1'b0;
    pop_one();   // removes the frame entry while the repeat is being pushed
    n_tests++;
    if ({fifo_empty, rd_repeat, rd_data} !== {1'b0, 1'b1, 24'hFB0408}) begin
      n_fail++; $display("FAIL repeat_entry: got %h required %h", {fifo_empty, rd_repeat, rd_data}, {2'b01, 24'hFB0408});
    end
    pop_one();
    n_tests++;
    if (hold_active !== 1'b1) begin n_fail++; $display("FAIL repeat_hold_on: got %b required 1", hold_active); end
    tick(HOLD + 10);
    n_tests++;
    if (hold_active !== 1'b0) begin n_fail++; $display("FAIL hold_expire: got %b required 0", hold_active); end
    send_repeat();
    n_tests++;
    if ({fifo_empty, err_cnt} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL late_repeat: empty=%b err=%0d required empty=1 err=0", fifo_empty, err_cnt);
    end
  endtask

  task automatic test_repeat_latency();
    do_reset();
    send_frame(32'hF708FB04);
    pop_one();
    repeat_in = 1'b1;
    tick(1);
    repeat_in = 1'b0;
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rep_latency_early: empty=%b required 1", fifo_empty); end
    tick(1);
    n_tests++;
    if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL rep_latency: empty=%b required 0", fifo_empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] f [6];
    do_reset();
    for (int i = 0; i < 6; i++) f[i] = mk_valid(8'($urandom), 8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) send_frame(f[i]);
    n_tests++;
    if ({fifo_full, overflow, rd_repeat, rd_data} !== {2'b11, model_entry(f[0], 1'b0)}) begin
      n_fail++; $display("FAIL overflow_fill: got %h required %h", {fifo_full, overflow, rd_repeat, rd_data}, {2'b11, model_entry(f[0], 1'b0)});
    end
    clr = 1'b1; tick(1); clr = 1'b0;
    n_tests++;
    if ({fifo_full, overflow} !== 2'b10) begin
      n_fail++; $display("FAIL overflow_clr: full/ovf=%b required 10", {fifo_full, overflow});
    end
    rx_data = f[5]; rx_complete = 1'b1;
    tick(2);
    rd_en = 1'b1;     // pop in the PUSH cycle while full
    tick(1);
    rd_en = 1'b0; rx_complete = 1'b0;
    tick(2);
    n_tests++;
    if ({fifo_full, overflow} !== 2'b10) begin
      n_fail++; $display("FAIL pop_push_full: full/ovf=%b required 10", {fifo_full, overflow});
    end
    for (int i = 1; i < 6; i++) begin
      if (i == 4) continue;
      n_tests++;
      if ({fifo_empty, rd_repeat, rd_data} !== {1'b0, model_entry(f[i], 1'b0)}) begin
        n_fail++; $display("FAIL drain_%0d: got %h required %h", i, {fifo_empty, rd_repeat, rd_data}, {1'b0, model_entry(f[i], 1'b0)});
      end
      pop_one();
    end
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: empty=%b required 1", fifo_empty); end
  endtask

  task automatic test_collisions();
    logic [31:0] fa, fb, bad;
    fa = mk_valid(8'($urandom), 8'($urandom));
    fb = mk_valid(8'($urandom), 8'($urandom));
    // Repeat arriving while the frame is in CHECK is held and serviced afterwards.
    do_reset();
    rx_data = fa; rx_complete = 1'b1;
    tick(1);
    repeat_in = 1'b1;
    tick(1);
    repeat_in = 1'b0; rx_complete = 1'b0;
    tick(5);
    n_tests++;
    if ({rd_repeat, rd_data} !== model_entry(fa, 1'b0)) begin
      n_fail++; $display("FAIL pend_first: got %h required %h", {rd_repeat, rd_data}, model_entry(fa, 1'b0));
    end
    pop_one();
    n_tests++;
    if ({fifo_empty, rd_repeat, rd_data} !== {1'b0, model_entry(fa, 1'b1)}) begin
      n_fail++; $display("FAIL pend_repeat: got %h required %h", {fifo_empty, rd_repeat, rd_data}, {1'b0, model_entry(fa, 1'b1)});
    end
    pop_one();
    // Frame and repeat in the same idle cycle: only the frame.
    do_reset();
    rx_data = fb; rx_complete = 1'b1; repeat_in = 1'b1;
    tick(1);
    repeat_in = 1'b0;
    tick(1);
    rx_complete = 1'b0;
    tick(5);
    n_tests++;
    if ({fifo_empty, rd_repeat, rd_data} !== {1'b0, model_entry(fb, 1'b0)}) begin
      n_fail++; $display("FAIL same_cycle_frame: got %h required %h", {fifo_empty, rd_repeat, rd_data}, {1'b0, model_entry(fb, 1'b0)});
    end
    pop_one();
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL same_cycle_only_one: empty=%b required 1", fifo_empty); end
    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bad = $urandom;
      bad[31:24] = ~bad[23:16] ^ 8'h01;
      rx_data = bad; rx_complete = 1'b1;
      tick(2);
      rx_complete = 1'b0;
      tick(2);
    end
    tick(2);
    n_tests++;
    if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d required 255", err_cnt); end
    // clr in the same cycle as an increment leaves zero.
    rx_data = bad; rx_complete = 1'b1;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0; rx_complete = 1'b0;
    tick(3);
    n_tests++;
    if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_wins: got %0d required 0", err_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [36:0] got;
    do_reset();
    send_frame(32'hF708FB04);
    send_frame(32'hF608FB04);
    rx_data = mk_valid(8'h33, 8'h44); rx_complete = 1'b1;
    tick(2);
    reset = 1'b1;     // asserted during PUSH
    tick(1);
    got = {fifo_empty, fifo_full, overflow, hold_active, rd_repeat, rd_data, err_cnt};
    n_tests++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 8'h0}) begin
      n_fail++; $display("FAIL reset_mid: got %h required %h", got, {5'b10000, 24'h0, 8'h0});
    end
    reset = 1'b0;     // rx_complete still high across release
    tick(6);
    n_tests++;
    if ({fifo_empty, err_cnt} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL reset_high_level: empty=%b err=%0d required empty=1 err=0", fifo_empty, err_cnt);
    end
    rx_complete = 1'b0;
    tick(1);
  endtask

  task automatic test_random();
    logic [24:0] q [$];
    logic [23:0] last;
    logic [31:0] f;
    int          m_err;
    bit          m_ovf, m_hold;
    int          since;
    int          kind;
    do_reset();
    m_err = 0; m_ovf = 1'b0; m_hold = 1'b0; since = 0; last = '0;
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        if ($urandom_range(0, 1) == 0 || since > HOLD / 2) f = mk_valid(8'($urandom), 8'($urandom));
        else f = $urandom;
        send_frame(f);
        since += 5;
        if (model_valid(f)) begin
          last = model_entry(f, 1'b0)[23:0];
          if (q.size() < DEPTH) q.push_back({1'b0, last}); else m_ovf = 1'b1;
          m_hold = 1'b1; since = 0;
        end else if (m_err < 255) begin
          m_err++;
        end
      end else if (kind <= 7) begin
        send_repeat();
        since += 4;
        if (m_hold) begin
          if (q.size() < DEPTH) q.push_back({1'b1, last}); else m_ovf = 1'b1;
          since = 0;
        end
      end
      n_tests++;
      if ({fifo_empty, fifo_full, overflow, err_cnt} !== {q.size() == 0, q.size() == DEPTH, m_ovf, 8'(m_err)}) begin
        n_fail++; $display("FAIL rand_status_%0d: empty/full/ovf/err got %b%b%b/%0d required %b%b%b/%0d", it,
                           fifo_empty, fifo_full, overflow, err_cnt, q.size() == 0, q.size() == DEPTH, m_ovf, m_err);
      end
      if (q.size() != 0) begin
        n_tests++;
        if ({rd_repeat, rd_data} !== q[0]) begin
          n_fail++; $display("FAIL rand_head_%0d: got %h required %h", it, {rd_repeat, rd_data}, q[0]);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        pop_one();
        since += 1;
        if (q.size() != 0) void'(q.pop_front());
      end
      if ($urandom_range(0, 19) == 0) begin
        clr = 1'b1; tick(1); clr = 1'b0;
        since += 1;
        m_err = 0; m_ovf = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_frame();
    test_repeat();
    test_repeat_latency();
    test_overflow();
    test_collisions();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
